// File: rtl/gray_track_if.sv
// Gray-stream interface between a Gray-coded position source and gray_track.
//   din/din_vld/clr : sample, sample-valid and soft clear (source -> tracker)
//   bin/step/dir/err/pos/err_cnt/locked : tracker status (tracker -> consumer)
interface gray_track_if #(
    parameter int W     = 4,
    parameter int POS_W = 8,
    parameter int ERR_W = 8
);
    logic [W-1:0]     din;
    logic             din_vld;
    logic             clr;
    logic [W-1:0]     bin;
    logic             step;
    logic             dir;
    logic             err;
    logic [POS_W-1:0] pos;
    logic [ERR_W-1:0] err_cnt;
    logic             locked;

    modport master (
        output din, din_vld, clr,
        input  bin, step, dir, err, pos, err_cnt, locked
    );

    modport slave (
        input  din, din_vld, clr,
        output bin, step, dir, err, pos, err_cnt, locked
    );
endinterface

// File: rtl/gray_track.sv
// gray_track: decodes a W-bit Gray stream, classifies each change against the
// previous sample (hold / up / down / illegal jump), and keeps a wrapping
// signed position plus a saturating illegal-jump counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : gray_track_if slave (din, din_vld, clr in; status outputs out)
//
//   state | meaning
//   IDLE  | no reference sample yet; next valid sample locks without a step
//   TRACK | reference held in bin; each valid sample is classified against it
module gray_track #(
    parameter int W     = 4,
    parameter int POS_W = 8,
    parameter int ERR_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    gray_track_if.slave   bus
);
    typedef enum logic {IDLE, TRACK} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     bin_q, bin_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [W-1:0]     new_bin;
    logic [W-1:0]     delta;

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        new_bin = '0;
        for (int i = 0; i < W; i++) begin
            new_bin[i] = ^(bus.din >> i);
        end
    end

    // Modulo-2^W difference makes 15->0 an up-step and 0->15 a down-step.
    assign delta = new_bin - bin_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            pos_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            err_q     <= err_d;
            pos_q     <= pos_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        pos_d     = pos_q;
        err_cnt_d = err_cnt_q;

        if (bus.clr) begin
            // Clear wins over a coincident sample; bin and dir keep their values.
            state_d   = IDLE;
            pos_d     = '0;
            err_cnt_d = '0;
        end else if (bus.din_vld) begin
            case (state_q)
                IDLE: begin
                    bin_d   = new_bin;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (delta == W'(0)) begin
                        // hold
                    end else if (delta == W'(1)) begin
                        step_d = 1'b1;
                        dir_d  = 1'b1;
                        pos_d  = pos_q + POS_W'(1);
                        bin_d  = new_bin;
                    end else if (delta == {W{1'b1}}) begin
                        step_d = 1'b1;
                        dir_d  = 1'b0;
                        pos_d  = pos_q - POS_W'(1);
                        bin_d  = new_bin;
                    end else begin
                        // Illegal jump: flag it and resync to the new sample.
                        err_d = 1'b1;
                        bin_d = new_bin;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.bin     = bin_q;
    assign bus.step    = step_q;
    assign bus.dir     = dir_q;
    assign bus.err     = err_q;
    assign bus.pos     = pos_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.locked  = (state_q == TRACK);
endmodule

// File: tb/tb_gray_track.sv
module tb_gray_track;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    gray_track_if #(.W(4), .POS_W(8), .ERR_W(8)) bus ();

    gray_track #(.W(4), .POS_W(8), .ERR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int step;
        int dir;
        int err;
        int pos;
        int errc;
        int locked;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state, in plain integers.
    int m_bin = 0, m_dir = 1, m_pos = 0, m_errc = 0, m_locked = 0;

    function automatic int gray_of(int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int bin_of(int g);
        return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
    endfunction

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of stimulus and push the model's expected outputs.
    task automatic cycle(input bit rst, input bit vld, input int g, input bit c);
        exp_t e;
        int   nb, d;
        @(negedge clk);
        rst_n       = rst;
        bus.din_vld = vld;
        bus.din     = 4'(g);
        bus.clr     = c;
        e.step = 0;
        e.err  = 0;
        if (!rst) begin
            m_bin = 0; m_dir = 1; m_pos = 0; m_errc = 0; m_locked = 0;
        end else if (c) begin
            m_locked = 0; m_pos = 0; m_errc = 0;
        end else if (vld) begin
            nb = bin_of(g);
            if (!m_locked) begin
                m_bin = nb;
                m_locked = 1;
            end else begin
                d = (nb - m_bin + 16) % 16;
                if (d == 1) begin
                    e.step = 1; m_dir = 1; m_pos = (m_pos + 1) % 256; m_bin = nb;
                end else if (d == 15) begin
                    e.step = 1; m_dir = 0; m_pos = (m_pos + 255) % 256; m_bin = nb;
                end else if (d != 0) begin
                    e.err = 1; m_bin = nb;
                    if (m_errc < 255) m_errc++;
                end
            end
        end
        e.bin = m_bin; e.dir = m_dir; e.pos = m_pos; e.errc = m_errc; e.locked = m_locked;
        exp_q.push_back(e);
    endtask

    task automatic feed(input int g);
        cycle(1'b1, 1'b1, g, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle; compare 1 ns after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bin",     int'(bus.bin),     e.bin);
                chk("step",    int'(bus.step),    e.step);
                chk("dir",     int'(bus.dir),     e.dir);
                chk("err",     int'(bus.err),     e.err);
                chk("pos",     int'(bus.pos),     e.pos);
                chk("err_cnt", int'(bus.err_cnt), e.errc);
                chk("locked",  int'(bus.locked),  e.locked);
                if (bus.step && bus.err) chk("step_err_excl", 1, 0);
            end
        end
    end

    initial begin
        int g, nb, r;
        bus.din = '0;
        bus.din_vld = 1'b0;
        bus.clr = 1'b0;

        // Reset, lock, illegal jump
        cycle(1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b1, 4'b0110, 1'b1);
        feed(4'b0010);
        feed(4'b0111);

        // Up sequence with wrap
        cycle(1'b1, 1'b0, 0, 1'b1);
        feed(4'b1001);
        feed(4'b1000);
        feed(4'b0000);

        // Down wrap and hold
        feed(4'b1000);
        feed(4'b1000);

        // Single-bit Gray flip that is illegal, then down step
        cycle(1'b1, 1'b0, 0, 1'b1);
        feed(4'b0000);
        feed(4'b0100);
        feed(4'b0101);

        // clr together with din_vld
        cycle(1'b1, 1'b1, 4'b0001, 1'b1);

        // Saturation: 260 illegal jumps (bin 0 <-> bin 8)
        feed(gray_of(0));
        for (int i = 0; i < 260; i++) feed(gray_of((i % 2 == 0) ? 8 : 0));

        // Accumulator overflow with idle gaps
        cycle(1'b1, 1'b0, 0, 1'b1);
        feed(gray_of(0));
        for (int i = 1; i <= 128; i++) begin
            feed(gray_of(i % 16));
            if (i % 5 == 0) cycle(1'b1, 1'b0, $urandom_range(0, 15), 1'b0);
        end

        // Reset mid-stream drops the sample; re-lock without a step
        cycle(1'b0, 1'b1, gray_of(1), 1'b0);
        feed(gray_of(5));
        feed(gray_of(6));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      nb = m_bin + 1;
            else if (r < 6) nb = m_bin + 15;
            else if (r < 8) nb = m_bin;
            else            nb = $urandom_range(0, 15);
            g = gray_of(nb % 16);
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) != 0), g,
                  ($urandom_range(0, 99) == 0));
        end

        cycle(1'b1, 1'b0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
